// File: rtl/li_air_screening_scheduler.sv
// li_air_screening_scheduler
//   Round-robin arbiter that shares one lithium-air quantum engine between
//   NUM_REQ screening requesters. A granted challenge is issued to the engine
//   as a one-cycle pulse, the scheduler then waits for a breakthrough or a
//   timeout and returns the result on a valid/ready response channel.
//
//   Optional feature: define BEST_TRACK_EN to keep a running best result
//   (highest non-timeout impact, ties keep the older entry). With the macro
//   undefined the best_* outputs are tied to zero.
//
//   Handshake rules (both channels): a transfer happens on a rising edge where
//   valid and ready are both 1. req_ready is a combinational one-hot grant that
//   is only offered in IDLE; rsp_valid is held with stable fields until
//   rsp_ready is seen, and drops the cycle after the transfer.
//
//   dbg_state exposes the FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP).
module li_air_screening_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int CHAL_W      = 1024,
  parameter int TIMEOUT_CYC = 400
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*CHAL_W-1:0] req_challenge,
  output logic [CHAL_W-1:0]         eng_challenges,
  output logic                      eng_challenge_valid,
  input  logic                      eng_breakthrough,
  input  logic [31:0]               eng_impact,
  input  logic [2:0]                eng_material,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [31:0]               rsp_impact,
  output logic [2:0]                rsp_material,
  output logic                      rsp_timeout,
  output logic                      busy,
  output logic [15:0]               jobs_done,
  output logic [31:0]               best_impact,
  output logic [2:0]                best_material,
  output logic [ID_W-1:0]           best_id,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [CHAL_W-1:0]   chal_q, chal_d;
  logic [15:0]         timer_q, timer_d;
  logic [31:0]         impact_q, impact_d;
  logic [2:0]          mat_q, mat_d;
  logic                to_q, to_d;
  logic [15:0]         jobs_q, jobs_d;

  logic                found;
  logic [ID_W-1:0]     grant_id;
  logic [ID_W:0]       slot;
  logic                rsp_fire;

  // Round-robin search: first valid requester starting at ptr_q, wrapping.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    slot     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (slot >= (ID_W+1)'(NUM_REQ)) slot = slot - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[slot[ID_W-1:0]]) begin
        found    = 1'b1;
        grant_id = slot[ID_W-1:0];
      end
    end
  end

  // One-hot grant, offered only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && found && !reset) req_ready[grant_id] = 1'b1;
  end

  assign rsp_fire = (state_q == S_RESP) && rsp_ready;

  // Next-state and datapath updates for the job sequencer.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    chal_d   = chal_q;
    timer_d  = timer_q;
    impact_d = impact_q;
    mat_d    = mat_q;
    to_d     = to_q;
    jobs_d   = jobs_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          id_d    = grant_id;
          chal_d  = req_challenge[grant_id*CHAL_W +: CHAL_W];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A breakthrough seen here belongs to an older challenge; ignore it.
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng_breakthrough) begin
          impact_d = eng_impact;
          mat_d    = eng_material;
          to_d     = 1'b0;
          state_d  = S_RESP;
        end else if (timer_q == TIMER_LAST) begin
          impact_d = '0;
          mat_d    = '0;
          to_d     = 1'b1;
          state_d  = S_RESP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          ptr_d   = (id_q == LAST_ID) ? '0 : id_q + ID_W'(1);
          if (jobs_q != 16'hFFFF) jobs_d = jobs_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and job registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      chal_q   <= '0;
      timer_q  <= '0;
      impact_q <= '0;
      mat_q    <= '0;
      to_q     <= 1'b0;
      jobs_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      chal_q   <= chal_d;
      timer_q  <= timer_d;
      impact_q <= impact_d;
      mat_q    <= mat_d;
      to_q     <= to_d;
      jobs_q   <= jobs_d;
    end
  end

  assign eng_challenges      = chal_q;
  assign eng_challenge_valid = (state_q == S_ISSUE);
  assign rsp_valid           = (state_q == S_RESP);
  assign rsp_id              = id_q;
  assign rsp_impact          = impact_q;
  assign rsp_material        = mat_q;
  assign rsp_timeout         = to_q;
  assign busy                = (state_q != S_IDLE);
  assign jobs_done           = jobs_q;
  assign dbg_state           = state_q;

`ifdef BEST_TRACK_EN
  logic [31:0]     best_imp_q, best_imp_d;
  logic [2:0]      best_mat_q, best_mat_d;
  logic [ID_W-1:0] best_id_q, best_id_d;

  // Strictly larger non-timeout impact replaces the running best.
  always_comb begin
    best_imp_d = best_imp_q;
    best_mat_d = best_mat_q;
    best_id_d  = best_id_q;
    if (rsp_fire && !to_q && (impact_q > best_imp_q)) begin
      best_imp_d = impact_q;
      best_mat_d = mat_q;
      best_id_d  = id_q;
    end
  end

  // Running-best registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      best_imp_q <= '0;
      best_mat_q <= '0;
      best_id_q  <= '0;
    end else begin
      best_imp_q <= best_imp_d;
      best_mat_q <= best_mat_d;
      best_id_q  <= best_id_d;
    end
  end

  assign best_impact   = best_imp_q;
  assign best_material = best_mat_q;
  assign best_id       = best_id_q;
`else
  assign best_impact   = '0;
  assign best_material = '0;
  assign best_id       = '0;
`endif

endmodule
